// File: rtl/l12_k_poly_reader.sv
// Streams one 256-coefficient polynomial from M1 (32 words x 8 lanes) to the sub/add datapath.
// Latency: first coef_valid 3 cycles after start; 10 cycles per word (ISSUE, WAIT, 8 x STREAM).
// Backpressure: coef_valid holds with data/idx stable until coef_ready; no coefficient is dropped.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start, abort          stream request (IDLE only) / synchronous return to IDLE
//   M1_RAd, M1_RData      M1 synchronous read port (data one cycle after address)
//   coef_valid/ready      coefficient handshake; coef_data, coef_idx {word,lane}, coef_last
//   busy, done, coef_err  status: not IDLE / 1-cycle completion pulse / sticky >= Q flag
module l12_k_poly_reader #(
    parameter int COEF_W = 12,
    parameter int LANES  = 8,
    parameter int WORDS  = 32,
    parameter int RAD_W  = 5,
    parameter int Q      = 3329
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    abort,
    output logic [RAD_W-1:0]        M1_RAd,
    input  logic [LANES*COEF_W-1:0] M1_RData,
    output logic                    coef_valid,
    input  logic                    coef_ready,
    output logic [COEF_W-1:0]       coef_data,
    output logic [7:0]              coef_idx,
    output logic                    coef_last,
    output logic                    busy,
    output logic                    done,
    output logic                    coef_err
);

    localparam int LANE_W = $clog2(LANES);
    localparam logic [RAD_W-1:0]  LAST_WORD = RAD_W'(WORDS - 1);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);
    localparam logic [COEF_W-1:0] Q_C       = COEF_W'(Q);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_STREAM,
        S_DONE
    } state_t;

    state_t                    state_q, state_d;
    logic [RAD_W-1:0]          word_q, word_d;
    logic [LANE_W-1:0]         lane_q, lane_d;
    logic [LANES*COEF_W-1:0]   wbuf_q, wbuf_d;
    logic                      err_q, err_d;
    logic [COEF_W-1:0]         cur_coef;

    // Lane select out of the captured word.
    always_comb begin
        cur_coef = '0;
        for (int i = 0; i < LANES; i++) begin
            if (lane_q == LANE_W'(i)) begin
                cur_coef = wbuf_q[i*COEF_W +: COEF_W];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        lane_d     = lane_q;
        wbuf_d     = wbuf_q;
        err_d      = err_q;
        M1_RAd     = '0;
        coef_valid = 1'b0;
        coef_data  = '0;
        coef_idx   = '0;
        coef_last  = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;

        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start && !abort) begin
                    state_d = S_ISSUE;
                    word_d  = '0;
                    lane_d  = '0;
                    err_d   = 1'b0;
                end
            end
            S_ISSUE: begin
                M1_RAd  = word_q;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Read data for the address issued last cycle is on M1_RData now.
                M1_RAd  = word_q;
                wbuf_d  = M1_RData;
                state_d = S_STREAM;
            end
            S_STREAM: begin
                M1_RAd     = word_q;
                coef_valid = 1'b1;
                coef_data  = cur_coef;
                coef_idx   = {word_q, lane_q};
                coef_last  = (word_q == LAST_WORD) && (lane_q == LAST_LANE);
                if (coef_ready) begin
                    if (cur_coef >= Q_C) begin
                        err_d = 1'b1;
                    end
                    if (lane_q == LAST_LANE) begin
                        lane_d = '0;
                        if (word_q == LAST_WORD) begin
                            word_d  = '0;
                            state_d = S_DONE;
                        end else begin
                            word_d  = word_q + RAD_W'(1);
                            state_d = S_ISSUE;
                        end
                    end else begin
                        lane_d = lane_q + LANE_W'(1);
                    end
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort wins over any handshake or start in the same cycle; the error flag
        // keeps its pre-abort value.
        if (abort) begin
            state_d = S_IDLE;
            word_d  = '0;
            lane_d  = '0;
            err_d   = err_q;
        end
    end

    assign coef_err = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            word_q  <= '0;
            lane_q  <= '0;
            wbuf_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            lane_q  <= lane_d;
            wbuf_q  <= wbuf_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_l12_k_poly_reader.sv
module tb_l12_k_poly_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        coef_ready = 1'b0;
    logic [4:0]  m1_rad;
    logic [95:0] m1_rdata = '0;
    logic        coef_valid;
    logic [11:0] coef_data;
    logic [7:0]  coef_idx;
    logic        coef_last;
    logic        busy;
    logic        done;
    logic        coef_err;

    int checks = 0;
    int errors = 0;

    logic [11:0] mem [256];

    l12_k_poly_reader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .M1_RAd     (m1_rad),
        .M1_RData   (m1_rdata),
        .coef_valid (coef_valid),
        .coef_ready (coef_ready),
        .coef_data  (coef_data),
        .coef_idx   (coef_idx),
        .coef_last  (coef_last),
        .busy       (busy),
        .done       (done),
        .coef_err   (coef_err)
    );

    always #5 clk = ~clk;

    // M1 model: synchronous read, 8 lanes per word, lane 0 in the low bits.
    always @(posedge clk) begin
        for (int l = 0; l < 8; l++) begin
            m1_rdata[l*12 +: 12] <= mem[m1_rad*8 + l];
        end
    end

    typedef struct {
        bit rnd;      // random ready instead of ready held high
        int a_idx;    // first overwritten coefficient (-1 = none)
        int a_val;
        int b_idx;    // second overwritten coefficient (-1 = none)
        int b_val;
        bit exp_err;  // coef_err expected at done
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic load_mem(input int a_idx, input int a_val, input int b_idx, input int b_val);
        for (int i = 0; i < 256; i++) mem[i] = 12'(i);
        if (a_idx >= 0) mem[a_idx] = 12'(a_val);
        if (b_idx >= 0) mem[b_idx] = 12'(b_val);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_valid"}, coef_valid, 0);
        chk({tag, "_data"},  coef_data, 0);
        chk({tag, "_idx"},   coef_idx, 0);
        chk({tag, "_last"},  coef_last, 0);
        chk({tag, "_busy"},  busy, 0);
        chk({tag, "_done"},  done, 0);
        chk({tag, "_err"},   coef_err, 0);
        chk({tag, "_rad"},   m1_rad, 0);
    endtask

    // Streams one polynomial from start to done. Cycle k is the k-th negedge after
    // the negedge that raised start. poke_cyc > 0 re-pulses start while busy.
    task automatic run_stream(input bit rnd, input int poke_cyc, input bit exp_final_err);
        int          exp_idx;
        int          first_valid;
        int          done_cyc;
        int          n_done;
        bit          exp_err;
        bit          prev_stall;
        logic [11:0] prev_data;
        logic [7:0]  prev_idx;

        exp_idx     = 0;
        first_valid = -1;
        done_cyc    = -1;
        n_done      = 0;
        exp_err     = 1'b0;
        prev_stall  = 1'b0;
        prev_data   = '0;
        prev_idx    = '0;

        @(negedge clk);
        start = 1'b1;
        for (int cyc = 1; cyc <= 1200 && n_done == 0; cyc++) begin
            @(negedge clk);
            start = (cyc == poke_cyc);
            chk("coef_err_track", coef_err, exp_err);
            if (prev_stall) begin
                chk("hold_valid", coef_valid, 1);
                chk("hold_data", coef_data, prev_data);
                chk("hold_idx", coef_idx, prev_idx);
            end
            if (coef_valid && first_valid < 0) first_valid = cyc;
            coef_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (coef_valid && coef_ready) begin
                chk("idx", coef_idx, exp_idx);
                chk("data", coef_data, mem[exp_idx & 255]);
                chk("last", coef_last, exp_idx == 255);
                chk("rad", m1_rad, exp_idx >> 3);
                if (mem[exp_idx & 255] >= 12'd3329) exp_err = 1'b1;
                exp_idx++;
            end
            prev_stall = coef_valid && !coef_ready;
            prev_data  = coef_data;
            prev_idx   = coef_idx;
            if (done) begin
                n_done++;
                done_cyc = cyc;
            end
        end
        chk("done_count", n_done, 1);
        chk("accepted_count", exp_idx, 256);
        chk("final_err", coef_err, exp_final_err);
        chk("first_valid_cycle", first_valid, 3);
        // 320 cycles of ISSUE/WAIT/STREAM occupancy, then the DONE cycle.
        if (!rnd) chk("done_cycle", done_cyc, 321);
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("idle_after_done", busy, 0);
        coef_ready = 1'b0;
    endtask

    vec_t tv [5];

    initial begin
        int found;
        int n;

        tv[0] = '{rnd: 1'b0, a_idx: -1,  a_val: 0,    b_idx: -1, b_val: 0,    exp_err: 1'b0};
        tv[1] = '{rnd: 1'b1, a_idx: -1,  a_val: 0,    b_idx: -1, b_val: 0,    exp_err: 1'b0};
        tv[2] = '{rnd: 1'b0, a_idx: 139, a_val: 3329, b_idx: 16, b_val: 4095, exp_err: 1'b1};
        tv[3] = '{rnd: 1'b1, a_idx: 139, a_val: 3329, b_idx: -1, b_val: 0,    exp_err: 1'b1};
        tv[4] = '{rnd: 1'b0, a_idx: 140, a_val: 3328, b_idx: -1, b_val: 0,    exp_err: 1'b0};

        load_mem(-1, 0, -1, 0);

        // Reset state
        #2;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("post_reset");

        // Full streams: ordering, backpressure, error flag, boundary at Q
        for (int t = 0; t < 5; t++) begin
            load_mem(tv[t].a_idx, tv[t].a_val, tv[t].b_idx, tv[t].b_val);
            run_stream(tv[t].rnd, 0, tv[t].exp_err);
        end

        // start while busy is ignored: exactly one done, no second run
        load_mem(-1, 0, -1, 0);
        run_stream(1'b0, 50, 1'b0);
        n = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            n += int'(done) + int'(busy);
        end
        chk("no_queued_start", n, 0);

        // abort at word 9 lane 5 (idx 77), with coef_err already set by idx 16
        load_mem(16, 4095, -1, 0);
        @(negedge clk);
        start = 1'b1;
        coef_ready = 1'b1;
        found = 0;
        for (int c = 0; c < 400 && found == 0; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (coef_valid && coef_idx == 8'd77) found = 1;
        end
        chk("abort_point_reached", found, 1);
        coef_ready = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_valid", coef_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_err_kept", coef_err, 1);
        chk("abort_rad", m1_rad, 0);
        n = 0;
        repeat (5) begin
            @(negedge clk);
            n += int'(done);
        end
        chk("abort_no_done", n, 0);

        // start together with abort is ignored (err not cleared either)
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        chk("start_abort_busy", busy, 0);
        chk("start_abort_err", coef_err, 1);

        // restart after abort begins at idx 0; idx 0 is out of range so err rises
        load_mem(0, 4000, -1, 0);
        start = 1'b1;
        coef_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("restart_busy", busy, 1);
        chk("restart_rad", m1_rad, 0);
        chk("restart_err_cleared", coef_err, 0);
        @(negedge clk);
        @(negedge clk);
        chk("restart_valid", coef_valid, 1);
        chk("restart_idx", coef_idx, 0);
        chk("restart_data", coef_data, 4000);
        repeat (17) @(negedge clk);
        chk("mid_stream_err", coef_err, 1);
        chk("mid_stream_busy", busy, 1);

        // async reset mid-stream, asserted away from any clock edge
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        coef_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("after_release");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
